// File: rtl/ltu_timer.sv
`default_nettype none
// ============================================================================
// Module   : ltu_timer
// Brief    : Prescaled tick timer fed by the LTU clock divider selection.
//            Counts ticks up to a live compare value. It raises a sticky
//            match flag and supports one-shot and periodic operation.
// Revision : 1.0 - initial release
// ============================================================================
module ltu_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       LTUCLKDIV,
    input  logic             LTUEN,
    input  logic             LTUMODE,
    input  logic [WIDTH-1:0] LTUCMP,
    input  logic             LTUIRQCLR,
    output logic [WIDTH-1:0] LTUCNT,
    output logic             LTUTICK,
    output logic             LTUIRQ,
    output logic             LTUBUSY,
    output logic             LTUDONE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_presc;
    logic [1:0]       r_div;
    logic             r_sync;
    logic [WIDTH-1:0] r_cnt;
    logic             r_irq;

    logic [2:0]       w_limit;
    logic             w_divchg;
    logic             w_tick;
    logic             w_match;

    // Prescaler terminal count for the registered divider selection
    always_comb begin
        w_limit = 3'd0;
        case (r_div)
            2'd0:    w_limit = 3'd0;
            2'd1:    w_limit = 3'd1;
            2'd2:    w_limit = 3'd3;
            default: w_limit = 3'd7;
        endcase
    end

    // A divider change suppresses the tick in the change cycle so a new
    // divisor never produces a shortened period. The first RUN cycle
    // (r_sync) is a start-up cycle in which the prescaler is held at zero.
    assign w_divchg = (LTUCLKDIV != r_div);
    assign w_tick   = (r_state == ST_RUN) && !r_sync && !w_divchg && (r_presc == w_limit);
    assign w_match  = w_tick && (r_cnt == LTUCMP);

    // Timer state, prescaler, counter and sticky match flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_presc <= 3'd0;
            r_div   <= 2'd0;
            r_sync  <= 1'b0;
            r_cnt   <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_div <= LTUCLKDIV;

            // Set has priority over a same-cycle clear
            if (LTUEN && w_match) begin
                r_irq <= 1'b1;
            end else if (LTUIRQCLR) begin
                r_irq <= 1'b0;
            end

            if (!LTUEN) begin
                r_state <= ST_IDLE;
                r_presc <= 3'd0;
                r_sync  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_RUN;
                        r_presc <= 3'd0;
                        r_sync  <= 1'b1;
                        r_cnt   <= '0;
                    end
                    ST_RUN: begin
                        if (r_sync) begin
                            r_sync  <= 1'b0;
                            r_presc <= 3'd0;
                        end else if (w_divchg) begin
                            r_presc <= 3'd0;
                        end else if (w_tick) begin
                            r_presc <= 3'd0;
                            if (w_match) begin
                                if (LTUMODE) begin
                                    r_cnt <= '0;
                                end else begin
                                    r_state <= ST_DONE;
                                end
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else begin
                            r_presc <= r_presc + 3'd1;
                        end
                    end
                    ST_DONE: begin
                        r_presc <= 3'd0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_presc <= 3'd0;
                        r_sync  <= 1'b0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign LTUCNT  = r_cnt;
    assign LTUTICK = w_tick;
    assign LTUIRQ  = r_irq;
    assign LTUBUSY = (r_state == ST_RUN);
    assign LTUDONE = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ltu_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltu_timer
// Brief    : Self-checking bench for ltu_timer. Expected output values are
//            queued with the cycle they must appear in and compared when
//            that cycle's outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ltu_timer;

    localparam int WIDTH = 16;
    localparam int SIG_CNT  = 0;
    localparam int SIG_IRQ  = 1;
    localparam int SIG_TICK = 2;
    localparam int SIG_BUSY = 3;
    localparam int SIG_DONE = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       div;
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] cmp;
    logic             irqclr;
    logic [WIDTH-1:0] cnt;
    logic             tick;
    logic             irq;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          cyc;
        int          sig;
        int unsigned val;
        string       tag;
    } exp_t;

    exp_t sb[$];

    ltu_timer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .LTUCLKDIV (div),
        .LTUEN     (en),
        .LTUMODE   (mode),
        .LTUCMP    (cmp),
        .LTUIRQCLR (irqclr),
        .LTUCNT    (cnt),
        .LTUTICK   (tick),
        .LTUIRQ    (irq),
        .LTUBUSY   (busy),
        .LTUDONE   (done)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge N, cyc == N
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int unsigned observe(input int s);
        case (s)
            SIG_CNT:  return int'(cnt);
            SIG_IRQ:  return int'(irq);
            SIG_TICK: return int'(tick);
            SIG_BUSY: return int'(busy);
            default:  return int'(done);
        endcase
    endfunction

    task automatic expect_at(input int c, input int s, input int unsigned v, input string t);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        e.tag = t;
        sb.push_back(e);
    endtask

    // Pop and compare every entry due in the cycle just completed
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                check_eq(sb[i].tag, observe(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    // Drive a run request; e is the edge that samples LTUEN=1
    task automatic start(input logic m, input int unsigned c, input logic [1:0] d, output int e);
        mode = m;
        cmp  = c[WIDTH-1:0];
        div  = d;
        en   = 1'b1;
        e    = cyc + 1;
    endtask

    task automatic pulse_clr();
        irqclr = 1'b1;
        step();
        irqclr = 1'b0;
    endtask

    int e, f, g, r;

    initial begin
        reset  = 1'b0;
        div    = 2'd0;
        en     = 1'b0;
        mode   = 1'b0;
        cmp    = '0;
        irqclr = 1'b0;
        #1;
        check_eq("rst_cnt",  int'(cnt),  0);
        check_eq("rst_irq",  int'(irq),  0);
        check_eq("rst_tick", int'(tick), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        step();
        step();
        reset = 1'b1;
        step();

        // Periodic, divide by 1, compare 3
        start(1'b1, 3, 2'd0, e);
        expect_at(e,     SIG_BUSY, 1, "p_busy");
        expect_at(e,     SIG_TICK, 0, "p_sync_tick");
        expect_at(e + 1, SIG_TICK, 1, "p_tick");
        expect_at(e + 1, SIG_CNT,  0, "p_cnt0");
        expect_at(e + 2, SIG_CNT,  1, "p_cnt1");
        expect_at(e + 3, SIG_CNT,  2, "p_cnt2");
        expect_at(e + 4, SIG_CNT,  3, "p_cnt3");
        expect_at(e + 4, SIG_IRQ,  0, "p_irq_early");
        expect_at(e + 5, SIG_IRQ,  1, "p_irq_rise");
        expect_at(e + 5, SIG_CNT,  0, "p_cnt_wrap");
        expect_at(e + 6, SIG_IRQ,  0, "p_irq_clr");
        expect_at(e + 8, SIG_IRQ,  0, "p_irq_gap");
        expect_at(e + 9, SIG_IRQ,  1, "p_irq_rerise");
        expect_at(e + 10, SIG_IRQ, 0, "p_irq_clr2");
        expect_at(e + 13, SIG_IRQ, 1, "p_irq_rerise2");
        expect_at(e + 15, SIG_IRQ, 1, "p_irq_kept");
        expect_at(e + 15, SIG_CNT, 0, "p_idle_cnt");
        expect_at(e + 15, SIG_BUSY, 0, "p_idle_busy");
        expect_at(e + 16, SIG_TICK, 0, "p_idle_tick");
        expect_at(e + 17, SIG_IRQ, 0, "p_idle_clr");
        wait_to(e + 5);
        pulse_clr();
        wait_to(e + 9);
        pulse_clr();
        wait_to(e + 14);
        en = 1'b0;
        wait_to(e + 16);
        pulse_clr();
        step();

        // One-shot, divide by 4, compare 2
        start(1'b0, 2, 2'd2, e);
        expect_at(e + 3,  SIG_TICK, 0, "o_tick_pre");
        expect_at(e + 4,  SIG_TICK, 1, "o_tick1");
        expect_at(e + 5,  SIG_TICK, 0, "o_tick_post");
        expect_at(e + 5,  SIG_CNT,  1, "o_cnt1");
        expect_at(e + 8,  SIG_TICK, 1, "o_tick2");
        expect_at(e + 9,  SIG_CNT,  2, "o_cnt2");
        expect_at(e + 12, SIG_TICK, 1, "o_tick3");
        expect_at(e + 12, SIG_IRQ,  0, "o_irq_early");
        expect_at(e + 12, SIG_DONE, 0, "o_done_early");
        expect_at(e + 13, SIG_IRQ,  1, "o_irq");
        expect_at(e + 13, SIG_DONE, 1, "o_done");
        expect_at(e + 13, SIG_BUSY, 0, "o_busy_off");
        expect_at(e + 13, SIG_CNT,  2, "o_cnt_hold");
        expect_at(e + 16, SIG_TICK, 0, "o_done_tick");
        expect_at(e + 20, SIG_CNT,  2, "o_cnt_hold2");
        expect_at(e + 20, SIG_DONE, 1, "o_done_hold");
        wait_to(e + 20);
        en = 1'b0;
        f = cyc + 1;
        expect_at(f, SIG_DONE, 0, "o_rearm_done");
        expect_at(f, SIG_CNT,  0, "o_rearm_cnt");
        expect_at(f, SIG_IRQ,  1, "o_rearm_irq");
        step();
        start(1'b0, 2, 2'd2, g);
        expect_at(g,      SIG_BUSY, 1, "o_rerun_busy");
        expect_at(g,      SIG_CNT,  0, "o_rerun_cnt");
        expect_at(g + 13, SIG_DONE, 1, "o_rerun_done");
        wait_to(g + 13);
        en = 1'b0;
        expect_at(g + 14, SIG_IRQ, 0, "o_idle_clr");
        pulse_clr();

        // Divider change 3 -> 1 on a would-be tick cycle
        start(1'b1, 1000, 2'd3, e);
        expect_at(e,      SIG_TICK, 0, "d_sync_tick");
        expect_at(e + 7,  SIG_TICK, 0, "d_tick_pre");
        expect_at(e + 8,  SIG_TICK, 1, "d_tick8");
        expect_at(e + 9,  SIG_CNT,  1, "d_cnt1");
        expect_at(e + 16, SIG_TICK, 0, "d_chg_tick");
        expect_at(e + 17, SIG_CNT,  1, "d_cnt_nochg");
        expect_at(e + 17, SIG_TICK, 0, "d_new_t0");
        expect_at(e + 18, SIG_TICK, 1, "d_new_t1");
        expect_at(e + 19, SIG_TICK, 0, "d_new_t2");
        expect_at(e + 19, SIG_CNT,  2, "d_cnt2");
        expect_at(e + 20, SIG_TICK, 1, "d_new_t3");
        expect_at(e + 21, SIG_TICK, 0, "d_new_t4");
        expect_at(e + 21, SIG_CNT,  3, "d_cnt3");
        expect_at(e + 22, SIG_TICK, 1, "d_new_t5");
        expect_at(e + 22, SIG_IRQ,  0, "d_irq");
        wait_to(e + 16);
        div = 2'd1;
        wait_to(e + 22);
        en = 1'b0;
        step();

        // Compare 0: match every tick, clear collides with match
        start(1'b1, 0, 2'd0, e);
        expect_at(e + 1, SIG_IRQ, 0, "c_irq0");
        expect_at(e + 2, SIG_IRQ, 1, "c_irq1");
        expect_at(e + 2, SIG_CNT, 0, "c_cnt0a");
        expect_at(e + 3, SIG_CNT, 0, "c_cnt0b");
        expect_at(e + 3, SIG_TICK, 1, "c_tick");
        expect_at(e + 4, SIG_IRQ, 1, "c_collide");
        expect_at(e + 5, SIG_IRQ, 1, "c_irq_hold");
        expect_at(e + 6, SIG_IRQ, 1, "c_idle_kept");
        expect_at(e + 6, SIG_BUSY, 0, "c_idle_busy");
        expect_at(e + 7, SIG_IRQ, 0, "c_idle_clr");
        wait_to(e + 3);
        pulse_clr();
        wait_to(e + 5);
        en = 1'b0;
        step();
        pulse_clr();
        step();

        // Compare lowered below the count: must wrap before matching
        start(1'b1, 100, 2'd0, e);
        expect_at(e + 51,    SIG_CNT, 50,    "w_cnt50");
        expect_at(e + 52,    SIG_CNT, 51,    "w_cnt51");
        expect_at(e + 101,   SIG_CNT, 100,   "w_cnt100");
        expect_at(e + 101,   SIG_IRQ, 0,     "w_no_early");
        expect_at(e + 65536, SIG_CNT, 65535, "w_cnt_max");
        expect_at(e + 65536, SIG_IRQ, 0,     "w_irq_max");
        expect_at(e + 65537, SIG_CNT, 0,     "w_cnt_roll");
        expect_at(e + 65542, SIG_CNT, 5,     "w_cnt5");
        expect_at(e + 65542, SIG_IRQ, 0,     "w_irq_pre");
        expect_at(e + 65543, SIG_IRQ, 1,     "w_irq_match");
        expect_at(e + 65543, SIG_CNT, 0,     "w_cnt_restart");
        wait_to(e + 51);
        cmp = 16'd5;
        wait_to(e + 65543);
        en = 1'b0;
        step();

        // Asynchronous reset mid-count with the flag pending
        start(1'b1, 20, 2'd0, e);
        wait_to(e + 8);
        check_eq("a_cnt_before", int'(cnt), 7);
        check_eq("a_irq_before", int'(irq), 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("a_cnt",  int'(cnt),  0);
        check_eq("a_irq",  int'(irq),  0);
        check_eq("a_tick", int'(tick), 0);
        check_eq("a_busy", int'(busy), 0);
        check_eq("a_done", int'(done), 0);
        step();
        step();
        reset = 1'b1;
        r = cyc;
        expect_at(r + 1, SIG_BUSY, 1, "a_run");
        expect_at(r + 1, SIG_CNT,  0, "a_cnt0");
        expect_at(r + 1, SIG_TICK, 0, "a_sync_tick");
        expect_at(r + 3, SIG_CNT,  1, "a_cnt1");
        expect_at(r + 3, SIG_IRQ,  0, "a_irq0");
        wait_to(r + 5);

        check_eq("sb_left", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ltu_timer.md
Name: ltu_timer

Overview:
- Programmable timer that sits directly downstream of the LTU clock divider.
- Consumes the divider selection published on LTUCLKDIVGET, generates a prescaled tick from it and counts those ticks up to a compare value.
- Raises a sticky interrupt flag on each match, in one-shot or periodic mode.
- Sole timebase consumer of the divider; its outputs go to the LTU status and interrupt logic.

Parameters:
- WIDTH, 16, width of the counter and the compare value.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset: 0 resets immediately, release is sampled on clk.
- LTUCLKDIV  in  2  divider select, driven from the divider's LTUCLKDIVGET. Prescale divisor = 2^LTUCLKDIV (1, 2, 4 or 8).
- LTUEN  in  1  level enable: 1 runs the timer, 0 stops and clears it.
- LTUMODE  in  1  0 = one-shot, 1 = periodic. Sampled on every tick.
- LTUCMP  in  WIDTH  compare value, compared live.
- LTUIRQCLR  in  1  single-cycle clear of LTUIRQ.
- LTUCNT  out  WIDTH  current tick count.
- LTUTICK  out  1  prescaled tick strobe, one clk wide, valid only in RUN.
- LTUIRQ  out  1  sticky match flag.
- LTUBUSY  out  1  1 while in RUN.
- LTUDONE  out  1  1 while in DONE.

Behaviour:
- Reset (reset=0), asynchronous:
  - state=IDLE, prescaler=0, LTUCNT=0.
  - LTUIRQ=0, LTUTICK=0, LTUBUSY=0, LTUDONE=0.
- Prescaler: 3-bit counter, limit = 2^LTUCLKDIV - 1.
  - LTUTICK = (state==RUN) && (prescaler==limit), combinational from registers.
  - In RUN, prescaler increments each cycle and returns to 0 on tick. Outside RUN it is held at 0.
- Divider change: LTUCLKDIV registered internally. Any change vs the registered copy clears the prescaler on the next edge, and no tick is issued that cycle. A new divisor always starts a full period; there are no short or glitched ticks.
- State machine:
  - IDLE: LTUCNT=0. LTUEN=1 -> RUN on next edge, with LTUCNT=0 and prescaler=0.
  - RUN, on tick with LTUCNT==LTUCMP:
    - Set LTUIRQ.
    - Periodic: LTUCNT<=0, stay in RUN.
    - One-shot: LTUCNT holds, go to DONE.
  - RUN, on tick with no match: LTUCNT<=LTUCNT+1, modulo 2^WIDTH.
  - DONE: LTUCNT holds, no ticks. Leaves only when LTUEN=0.
  - Any state with LTUEN=0: -> IDLE next edge, LTUCNT<=0, prescaler<=0. LTUIRQ is retained.
- Timing: first match sets LTUIRQ on edge 1 + (LTUCMP+1)*2^LTUCLKDIV after the edge that samples LTUEN=1. The periodic interval is (LTUCMP+1)*2^LTUCLKDIV cycles.
- Compare boundaries:
  - LTUCMP=0: match on every tick.
  - LTUCMP lowered below LTUCNT while running: the counter wraps through 2^WIDTH-1 to 0 before matching. No early match.
- LTUIRQ:
  - Set on match, cleared by LTUIRQCLR.
  - Match and clear in the same cycle: set wins.
  - Clear with no match: 0 on the next edge.
- LTUBUSY = (state==RUN) and LTUDONE = (state==DONE), both registered-state decodes.
- Reset asserted mid-count: everything returns to reset values immediately, including a pending LTUIRQ.

Test Plan:
- Periodic, LTUCLKDIV=0, LTUCMP=3, LTUEN=1 sampled at edge E: LTUIRQ rises at E+5. After a clear, LTUIRQ re-rises every 4 cycles. LTUCNT sequence 0,1,2,3,0.
- One-shot, LTUCLKDIV=2, LTUCMP=2:
  - LTUTICK every 4 cycles; LTUIRQ and LTUDONE at E+13; LTUCNT holds 2.
  - Re-arm requires LTUEN=0 (IDLE, LTUCNT=0), then LTUEN=1.
- Divider change mid-run, LTUCLKDIV 3->1: no tick in the change cycle, first new tick exactly 2 cycles after the prescaler clear, then every 2 cycles. No tick gap below 2 cycles.
- IRQ clear collision, periodic, LTUCMP=0, LTUCLKDIV=0: LTUIRQCLR pulsed on a match cycle -> LTUIRQ stays 1. LTUIRQCLR pulsed with LTUEN=0 -> LTUIRQ=0 next edge.
- Boundaries, WIDTH=16:
  - LTUCMP changed from 100 to 5 while LTUCNT=50: next match only after LTUCNT wraps 65535->0 and reaches 5.
  - LTUCMP=0: match on every tick.
- Async reset mid-run: reset=0 between edges with LTUCNT=7 and LTUIRQ=1 -> all outputs 0 immediately. After release with LTUEN=1: RUN on the first sampled edge, LTUCNT restarts from 0.
